// File: rtl/branch_unit_if.sv
// ============================================================================
// Module      : branch_unit_if
// Description : Op, redirect, BHT lookup and perf-counter bundle for branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_br_type;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_src1;
    logic [XLEN-1:0]  in_src2;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_trap_target;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic             redirect_valid;
    logic             redirect_ready;
    logic [XLEN-1:0]  redirect_pc;
    logic             redirect_misalign;
    logic [XLEN-1:0]  bht_lookup_pc;
    logic             bht_lookup_taken;
    logic [CNT_W-1:0] perf_branch_cnt;
    logic [CNT_W-1:0] perf_mispred_cnt;

    modport master (
        output in_valid, in_br_type, in_pc, in_src1, in_src2, in_imm,
               in_trap_target, in_pred_taken, in_pred_target,
               redirect_ready, bht_lookup_pc,
        input  in_ready, redirect_valid, redirect_pc, redirect_misalign,
               bht_lookup_taken, perf_branch_cnt, perf_mispred_cnt
    );

    modport slave (
        input  in_valid, in_br_type, in_pc, in_src1, in_src2, in_imm,
               in_trap_target, in_pred_taken, in_pred_target,
               redirect_ready, bht_lookup_pc,
        output in_ready, redirect_valid, redirect_pc, redirect_misalign,
               bht_lookup_taken, perf_branch_cnt, perf_mispred_cnt
    );
endinterface

`default_nettype wire

// File: rtl/branch_unit.sv
// ============================================================================
// Module      : branch_unit
// Description : Branch resolution, held IFU redirect, 2-bit BHT, perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_unit_if.slave  bu
);
    localparam int              c_IDX_W    = $clog2(BHT_ENTRIES);
    localparam logic [3:0]      c_BR_JAL   = 4'b0001;
    localparam logic [3:0]      c_BR_JALR  = 4'b0010;
    localparam logic [3:0]      c_BR_TRAP  = 4'b0011;
    localparam logic [3:0]      c_BR_BEQ   = 4'b1000;
    localparam logic [3:0]      c_BR_BNE   = 4'b1001;
    localparam logic [3:0]      c_BR_BLT   = 4'b1100;
    localparam logic [3:0]      c_BR_BGE   = 4'b1101;
    localparam logic [3:0]      c_BR_BLTU  = 4'b1110;
    localparam logic [3:0]      c_BR_BGEU  = 4'b1111;
    localparam logic [XLEN-1:0] c_INSN_LEN = XLEN'(4);

    logic                r_redirect_valid;
    logic [XLEN-1:0]     r_redirect_pc;
    logic                r_redirect_misalign;
    logic [CNT_W-1:0]    r_branch_cnt;
    logic [CNT_W-1:0]    r_mispred_cnt;
    logic [1:0]          r_bht [BHT_ENTRIES];

    logic                w_accept;
    logic                w_is_cond;
    logic                w_is_jump;
    logic                w_is_trap;
    logic                w_cond_true;
    logic                w_taken;
    logic                w_mispred;
    logic                w_eq;
    logic                w_lt;
    logic                w_ltu;
    logic [XLEN-1:0]     w_jalr_sum;
    logic [XLEN-1:0]     w_target;
    logic [XLEN-1:0]     w_next_pc;
    logic [c_IDX_W-1:0]  w_train_idx;
    logic [c_IDX_W-1:0]  w_lookup_idx;
    logic [1:0]          w_bht_cur;
    logic [1:0]          w_bht_next;
    logic                w_unused_lookup;

    assign bu.in_ready = !r_redirect_valid || bu.redirect_ready;
    assign w_accept    = bu.in_valid && bu.in_ready;

    assign w_eq  = (bu.in_src1 == bu.in_src2);
    assign w_lt  = ($signed(bu.in_src1) < $signed(bu.in_src2));
    assign w_ltu = (bu.in_src1 < bu.in_src2);

    // Unlisted encodings fall to the default and behave as "none".
    always_comb begin
        w_is_cond   = 1'b0;
        w_is_jump   = 1'b0;
        w_is_trap   = 1'b0;
        w_cond_true = 1'b0;
        case (bu.in_br_type)
            c_BR_JAL, c_BR_JALR: w_is_jump = 1'b1;
            c_BR_TRAP:           w_is_trap = 1'b1;
            c_BR_BEQ:  begin w_is_cond = 1'b1; w_cond_true = w_eq;   end
            c_BR_BNE:  begin w_is_cond = 1'b1; w_cond_true = !w_eq;  end
            c_BR_BLT:  begin w_is_cond = 1'b1; w_cond_true = w_lt;   end
            c_BR_BGE:  begin w_is_cond = 1'b1; w_cond_true = !w_lt;  end
            c_BR_BLTU: begin w_is_cond = 1'b1; w_cond_true = w_ltu;  end
            c_BR_BGEU: begin w_is_cond = 1'b1; w_cond_true = !w_ltu; end
            default: ;
        endcase
    end

    assign w_jalr_sum = bu.in_src1 + bu.in_imm;

    always_comb begin
        w_target = bu.in_pc + bu.in_imm;
        if (bu.in_br_type == c_BR_JALR) begin
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        end else if (w_is_trap) begin
            w_target = bu.in_trap_target;
        end
    end

    assign w_taken   = w_is_jump || w_is_trap || (w_is_cond && w_cond_true);
    assign w_next_pc = w_taken ? w_target : (bu.in_pc + c_INSN_LEN);
    assign w_mispred = w_is_trap ||
                       ((w_is_cond || w_is_jump) &&
                        ((w_taken != bu.in_pred_taken) ||
                         (w_taken && (w_target != bu.in_pred_target))));

    // A fresh accept overrides any handshake completing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid    <= 1'b0;
            r_redirect_pc       <= '0;
            r_redirect_misalign <= 1'b0;
        end else if (w_accept) begin
            r_redirect_valid <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc       <= w_next_pc;
                r_redirect_misalign <= w_next_pc[1];
            end
        end else if (r_redirect_valid && bu.redirect_ready) begin
            r_redirect_valid <= 1'b0;
        end
    end

    assign bu.redirect_valid    = r_redirect_valid;
    assign bu.redirect_pc       = r_redirect_pc;
    assign bu.redirect_misalign = r_redirect_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_accept) begin
            if (w_is_cond) r_branch_cnt  <= r_branch_cnt + CNT_W'(1);
            if (w_mispred) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign bu.perf_branch_cnt  = r_branch_cnt;
    assign bu.perf_mispred_cnt = r_mispred_cnt;

    assign w_train_idx = bu.in_pc[c_IDX_W+1:2];
    assign w_bht_cur   = r_bht[w_train_idx];

    always_comb begin
        w_bht_next = w_bht_cur;
        if (w_cond_true && (w_bht_cur != 2'b11)) begin
            w_bht_next = w_bht_cur + 2'b01;
        end else if (!w_cond_true && (w_bht_cur != 2'b00)) begin
            w_bht_next = w_bht_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && w_is_cond) begin
            r_bht[w_train_idx] <= w_bht_next;
        end
    end

    // Reads the registered array, so a same-cycle update is not yet visible.
    assign w_lookup_idx        = bu.bht_lookup_pc[c_IDX_W+1:2];
    assign bu.bht_lookup_taken = r_bht[w_lookup_idx][1];
    assign w_unused_lookup     = ^bu.bht_lookup_pc;

endmodule

`default_nettype wire

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Parametrised branch resolution unit for the pipelined core. It sits in EXU and accepts one control-transfer op per handshake. For each op it evaluates the full RV32/RV64 condition set and computes the actual target, then compares both against the IFU prediction. On a mispredict it drives a held redirect to IFU. It also owns a direct-mapped 2-bit BHT that IFU reads and EXU trains, plus performance counters.

Parameters:
XLEN, 32, datapath and PC width
BHT_ENTRIES, 16, BHT entry count; power of two, at least 2
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  op valid from EXU
in_ready  out  1  unit can accept op
in_br_type  in  4  0000 none, 0001 jal, 0010 jalr, 0011 trap(ecall/mret), 1000 beq, 1001 bne, 1100 blt, 1101 bge, 1110 bltu, 1111 bgeu; others as none
in_pc  in  XLEN  op PC
in_src1  in  XLEN  rs1 value
in_src2  in  XLEN  rs2 value
in_imm  in  XLEN  sign-extended offset
in_trap_target  in  XLEN  mtvec/mepc selected by CSR unit
in_pred_taken  in  1  IFU predicted taken
in_pred_target  in  XLEN  IFU predicted target
redirect_valid  out  1  redirect request to IFU
redirect_ready  in  1  IFU accepts redirect
redirect_pc  out  XLEN  correct next PC
redirect_misalign  out  1  redirect_pc[1] set (instruction-address-misaligned)
bht_lookup_pc  in  XLEN  IFU lookup PC
bht_lookup_taken  out  1  combinational prediction (counter MSB)
perf_branch_cnt  out  CNT_W  resolved conditional branches
perf_mispred_cnt  out  CNT_W  redirects issued

Behaviour:
- Reset (async, rst_n low): redirect_valid=0, redirect_pc=0, redirect_misalign=0, both perf counters=0, every BHT entry=2'b01 (weakly not-taken).
- Accept: in_ready = !redirect_valid || redirect_ready. An op is accepted when in_valid && in_ready.
- Condition evaluation:
  - beq/bne use equality.
  - blt/bge use signed compare.
  - bltu/bgeu use unsigned compare.
  - jal, jalr and trap are always taken.
  - none is never taken and is never a mispredict.
- Target:
  - jal and conditional ops: in_pc+in_imm.
  - jalr: (in_src1+in_imm) with bit0 cleared.
  - trap: in_trap_target.
  - All sums are modulo 2^XLEN.
  - Not-taken next PC is in_pc+4.
- Mispredict when either holds:
  - actual_taken != in_pred_taken; or
  - actual_taken && target != in_pred_target.
- Trap ops are always treated as mispredicts and always redirect.
- Latency: result is registered. On an accepted mispredicting op, redirect_valid rises the next cycle, with redirect_pc = taken ? target : in_pc+4. redirect_misalign = redirect_pc[1].
- Redirect hold: redirect_valid, redirect_pc and redirect_misalign are held stable until redirect_ready is high. The redirect clears in the cycle after the handshake.
- Simultaneous handshake and new accept: if redirect_ready && redirect_valid and a new op is accepted in the same cycle, the new op's result replaces the register. redirect_valid stays 1 only if the new op mispredicts.
- BHT index: pc[log2(BHT_ENTRIES)+1:2].
- BHT training: on accept of a conditional op, the indexed counter increments on taken and decrements on not-taken, saturating at 2'b11 and 2'b00. Writes take effect at the clock edge.
- BHT read/write collision: a lookup at the same index as a same-cycle update returns the pre-update value.
- Jumps and traps do not touch the BHT.
- Perf counters: perf_branch_cnt increments once per accepted conditional op. perf_mispred_cnt increments once per accepted mispredicting op. Both wrap modulo 2^CNT_W.
- Reset mid-operation: a pending redirect is dropped and the BHT is reinitialised. No partial update survives.

Test Plan:
- Reset, then lookup all indices -> bht_lookup_taken=0 everywhere; redirect_valid=0; both counters=0.
- beq with src1=src2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x120, misalign=0.
  - Same op with pred_taken=1, pred_target=0x120 -> no redirect; perf_branch_cnt=2 after both ops.
- blt with src1=0xFFFFFFFF, src2=1 -> taken. bltu with the same operands -> not taken; with pred_taken=1 -> redirect_pc=pc+4.
- jalr with src1=0x1003, imm=0 -> target 0x1002, misalign=1.
  - Hold redirect_ready=0 for 3 cycles -> in_ready=0 and outputs stable; the 4th cycle handshake clears redirect_valid.
- Three taken beq at pc=0x40 -> counter 01→10→11→11 (saturates); bht_lookup_taken=1 from the first update. A same-cycle lookup during the first update returns 0.
- Trap with trap_target=0x8000_0000 and a matching prediction -> redirect still issued to 0x8000_0000; perf_mispred_cnt increments.
  - Assert rst_n while a redirect is pending -> redirect_valid=0 immediately.
